lsu_req_ctrl: RTL and testbench

- Initiator side of the LSU VALID/READY load/store interface.
- Sits between the core's memory stage and the LSU.
- Turns one load/store per instruction into a single VALID/READY transaction, aligning store data and byte strobes, and extracting and extending load data.
- Stalls the pipeline until the transaction completes, the bus times out, or a misaligned access is rejected.

---
 rtl/singlecycle_pkg.sv | 22 ++
 rtl/lsu_fmt.sv | 54 +++++
 rtl/lsu_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_req_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// Shared types for the single-cycle core memory stage.
// Holds the LSU access-size encoding, the request FSM states and the
// default bus timeout.
package singlecycle_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_req_state_e;

    localparam int LSU_TIMEOUT_DEF = 64;

endpackage

// File: rtl/lsu_fmt.sv
// Purpose: store lane replication/strobes, load byte/half extraction and extension, misalign detect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when inputs and outputs are meaningful.
module lsu_fmt
    import singlecycle_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        wr,
    input  logic [31:0] st_src,
    input  logic [31:0] ld_raw,
    output logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed byte / halfword out of the raw word.
    // Halfword selection uses addr[1] only, so addr[0] is ignored when not trapping.
    always_comb begin
        ld_byte = ld_raw[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    // Size decode; reserved encodings fall through to the word case.
    always_comb begin
        st_data  = st_src;
        st_strb  = 4'b1111;
        ld_data  = ld_raw;
        misalign = 1'b0;
        case (funct3)
            LSU_B, LSU_BU: begin
                st_data = {4{st_src[7:0]}};
                if (wr) st_strb = 4'b0001 << addr_lo;
                ld_data = (funct3 == LSU_B) ? {{24{ld_byte[7]}}, ld_byte}
                                            : {24'h0, ld_byte};
            end
            LSU_H, LSU_HU: begin
                st_data  = {2{st_src[15:0]}};
                if (wr) st_strb = 4'b0011 << {addr_lo[1], 1'b0};
                ld_data  = (funct3 == LSU_H) ? {{16{ld_half[15]}}, ld_half}
                                             : {16'h0, ld_half};
                misalign = addr_lo[0];
            end
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/lsu_req_ctrl.sv
// Purpose: turns one memory-stage load/store into a single VALID/READY LSU transaction (optional LSU_MISALIGN_TRAP_EN).
// Latency: 3 cycles minimum (IDLE, BUSY with READY, RESP); misaligned trap takes IDLE->RESP.
// Backpressure: request held in BUSY until READY or TIMEOUT_CYC expires; pipeline stalled meanwhile.
module lsu_req_ctrl
    import singlecycle_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_en,
    input  logic              i_mem_wr,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_st_src,
    output logic              o_VALID,
    input  logic              i_READY,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [31:0]       o_st_data,
    output logic [3:0]        o_st_strb,
    output logic              o_lsu_wren,
    input  logic [31:0]       i_ld_data,
    output logic [31:0]       o_ld_result,
    output logic              o_done,
    output logic              o_stall,
    output logic              o_bus_err,
    output logic              o_misalign
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MIS_TRAP = 1'b1;
`else
    localparam bit MIS_TRAP = 1'b0;
`endif

    lsu_req_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       st_data_q;
    logic [3:0]        strb_q;
    logic [31:0]       ld_result_q;
    logic              err_q;
    logic              mis_q;

    logic [1:0]  fmt_addr_lo;
    logic [2:0]  fmt_funct3;
    logic        fmt_wr;
    logic [31:0] fmt_st_data;
    logic [3:0]  fmt_strb;
    logic [31:0] fmt_ld_data;
    logic        fmt_mis;
    logic        trap_mis;
    logic        timeout_hit;

    // In IDLE the formatter sees the live request; afterwards it sees the captured one.
    always_comb begin
        fmt_addr_lo = (state_q == IDLE) ? i_addr[1:0] : addr_q[1:0];
        fmt_funct3  = (state_q == IDLE) ? i_funct3    : funct3_q;
        fmt_wr      = (state_q == IDLE) ? i_mem_wr    : wr_q;
    end

    lsu_fmt u_fmt (
        .addr_lo  (fmt_addr_lo),
        .funct3   (fmt_funct3),
        .wr       (fmt_wr),
        .st_src   (i_st_src),
        .ld_raw   (i_ld_data),
        .st_data  (fmt_st_data),
        .st_strb  (fmt_strb),
        .ld_data  (fmt_ld_data),
        .misalign (fmt_mis)
    );

    assign trap_mis    = MIS_TRAP & fmt_mis;
    // READY in the last allowed cycle beats the timeout.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !i_READY;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_mem_en) state_d = trap_mis ? RESP : BUSY;
            BUSY:    if (i_READY || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request capture, wait counter and response registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            st_data_q   <= '0;
            strb_q      <= '0;
            ld_result_q <= '0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (i_mem_en) begin
                        addr_q    <= i_addr;
                        funct3_q  <= i_funct3;
                        wr_q      <= i_mem_wr;
                        st_data_q <= fmt_st_data;
                        strb_q    <= fmt_strb;
                        cnt_q     <= '0;
                        if (trap_mis) begin
                            mis_q       <= 1'b1;
                            ld_result_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (i_READY) begin
                        ld_result_q <= wr_q ? 32'h0 : fmt_ld_data;
                    end else if (timeout_hit) begin
                        err_q       <= 1'b1;
                        ld_result_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    mis_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_VALID     = (state_q == BUSY);
    assign o_lsu_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_st_data   = st_data_q;
    assign o_st_strb   = strb_q;
    assign o_lsu_wren  = wr_q & (state_q == BUSY);
    assign o_ld_result = ld_result_q;
    assign o_done      = (state_q == RESP);
    assign o_stall     = ((state_q == IDLE) & i_mem_en) | (state_q == BUSY);
    assign o_bus_err   = err_q;
    assign o_misalign  = mis_q & MIS_TRAP;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
module tb_lsu_req_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_mem_en = 1'b0;
    logic        i_mem_wr = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_st_src = 32'h0;
    logic        o_VALID;
    logic        i_READY = 1'b0;
    logic [31:0] o_lsu_addr;
    logic [31:0] o_st_data;
    logic [3:0]  o_st_strb;
    logic        o_lsu_wren;
    logic [31:0] i_ld_data = 32'h0;
    logic [31:0] o_ld_result;
    logic        o_done;
    logic        o_stall;
    logic        o_bus_err;
    logic        o_misalign;

    lsu_req_ctrl #(.TIMEOUT_CYC(8), .ADDR_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mem_en(i_mem_en), .i_mem_wr(i_mem_wr),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_st_src(i_st_src), .o_VALID(o_VALID),
        .i_READY(i_READY), .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data),
        .o_st_strb(o_st_strb), .o_lsu_wren(o_lsu_wren), .i_ld_data(i_ld_data),
        .o_ld_result(o_ld_result), .o_done(o_done), .o_stall(o_stall),
        .o_bus_err(o_bus_err), .o_misalign(o_misalign)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        wren;
    } req_t;

    typedef struct {
        logic        has_req;
        logic [31:0] ld;
        logic        err;
        logic        mis;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    resp_t mon_r;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: request fields checked every VALID cycle, response popped at o_done.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_VALID) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_valid", {31'h0, o_VALID}, 32'h0);
                end else begin
                    chk("req_addr", o_lsu_addr, req_q[0].addr);
                    chk("req_data", o_st_data, req_q[0].data);
                    chk("req_strb", {28'h0, o_st_strb}, {28'h0, req_q[0].strb});
                    chk("req_wren", {31'h0, o_lsu_wren}, {31'h0, req_q[0].wren});
                end
            end
            if (o_done) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", {31'h0, o_done}, 32'h0);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("resp_ld", o_ld_result, mon_r.ld);
                    chk("resp_err", {31'h0, o_bus_err}, {31'h0, mon_r.err});
                    chk("resp_mis", {31'h0, o_misalign}, {31'h0, mon_r.mis});
                    if (mon_r.has_req && req_q.size() > 0) void'(req_q.pop_front());
                end
            end
        end
    end

    // One access; rdy_dly = BUSY cycle index at which READY is raised, -1 = never.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] st, input logic [31:0] ld, input int rdy_dly,
                          input logic [31:0] e_data, input logic [3:0] e_strb,
                          input logic has_req, input logic [31:0] e_ld,
                          input logic e_err, input logic e_mis,
                          input int e_valid, input int e_stall);
        req_t  q;
        resp_t s;
        int    cyc, vcnt, scnt;
        bit    done;
        @(posedge i_clk); #1;
        i_mem_en = 1'b1; i_mem_wr = wr; i_funct3 = f3; i_addr = addr;
        i_st_src = st; i_ld_data = 32'h0; i_READY = 1'b0;
        if (has_req) begin
            q.addr = {addr[31:2], 2'b00}; q.data = e_data; q.strb = e_strb; q.wren = wr;
            req_q.push_back(q);
        end
        s.has_req = has_req; s.ld = e_ld; s.err = e_err; s.mis = e_mis;
        resp_q.push_back(s);
        cyc = 0; vcnt = 0; scnt = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
            if (o_stall) scnt++;
            if (o_VALID) begin
                if (vcnt == rdy_dly) begin
                    i_READY = 1'b1;
                    i_ld_data = ld;
                end
                vcnt++;
            end
            if (o_done) begin
                done = 1;
                i_mem_en = 1'b0;
                i_READY = 1'b0;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_wait: got no o_done expected o_done within 60 cycles");
            i_mem_en = 1'b0; i_READY = 1'b0;
        end
        chk("valid_cycles", vcnt, e_valid);
        chk("stall_cycles", scnt, e_stall);
        chk("done_cycle", cyc, has_req ? e_valid + 2 : 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_valid", {31'h0, o_VALID}, 32'h0);
        chk("rst_done", {31'h0, o_done}, 32'h0);
        chk("rst_strb", {28'h0, o_st_strb}, 32'h0);
        chk("rst_addr", o_lsu_addr, 32'h0);
        chk("rst_data", o_st_data, 32'h0);
        chk("rst_ld", o_ld_result, 32'h0);
        chk("rst_flags", {29'h0, o_bus_err, o_misalign, o_lsu_wren}, 32'h0);
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // SB 0xA5 at 0x2003, READY immediately
        access(1'b1, 3'b000, 32'h2003, 32'h000000A5, 32'h0, 0,
               32'hA5A5A5A5, 4'b1000, 1'b1, 32'h0, 1'b0, 1'b0, 1, 2);
        // Loads from word 0x12F03456
        access(1'b0, 3'b000, 32'h2002, 32'h0, 32'h12F03456, 0,
               32'h0, 4'b1111, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 1, 2);
        access(1'b0, 3'b100, 32'h2002, 32'h0, 32'h12F03456, 0,
               32'h0, 4'b1111, 1'b1, 32'h000000F0, 1'b0, 1'b0, 1, 2);
        access(1'b0, 3'b101, 32'h2002, 32'h0, 32'h12F03456, 0,
               32'h0, 4'b1111, 1'b1, 32'h000012F0, 1'b0, 1'b0, 1, 2);
        access(1'b0, 3'b001, 32'h2000, 32'h0, 32'h12F03456, 0,
               32'h0, 4'b1111, 1'b1, 32'h00003456, 1'b0, 1'b0, 1, 2);
        // LW with READY delayed 5 cycles
        access(1'b0, 3'b010, 32'h2004, 32'h0, 32'hDEADBEEF, 5,
               32'h0, 4'b1111, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 6, 7);
        // Result holds while idle
        repeat (3) @(negedge i_clk);
        chk("ld_hold", o_ld_result, 32'hDEADBEEF);
        // Timeout (8 cycles) with READY never raised
        access(1'b0, 3'b010, 32'h3000, 32'h0, 32'h55555555, -1,
               32'h0, 4'b1111, 1'b1, 32'h0, 1'b1, 1'b0, 8, 9);
        // READY in the last allowed cycle wins over the timeout
        access(1'b0, 3'b010, 32'h3004, 32'h0, 32'hCAFEF00D, 7,
               32'h0, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 8, 9);
        // Misaligned SH at 0x2001
`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b1, 3'b001, 32'h2001, 32'h1234ABCD, 32'h0, 0,
               32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b1, 0, 1);
`else
        access(1'b1, 3'b001, 32'h2001, 32'h1234ABCD, 32'h0, 0,
               32'hABCDABCD, 4'b0011, 1'b1, 32'h0, 1'b0, 1'b0, 1, 2);
`endif
        // SH upper half, then SW; stores return 0 in the result
        access(1'b1, 3'b001, 32'h2006, 32'h0000BEEF, 32'h0, 1,
               32'hBEEFBEEF, 4'b1100, 1'b1, 32'h0, 1'b0, 1'b0, 2, 3);
        access(1'b1, 3'b010, 32'h2008, 32'h11223344, 32'h0, 0,
               32'h11223344, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0, 1, 2);

        // Reset in the middle of BUSY
        @(posedge i_clk); #1;
        i_mem_en = 1'b1; i_mem_wr = 1'b0; i_funct3 = 3'b010; i_addr = 32'h4000;
        i_st_src = 32'h0; i_READY = 1'b0;
        req_q.push_back('{addr: 32'h4000, data: 32'h0, strb: 4'b1111, wren: 1'b0});
        repeat (3) @(posedge i_clk);
        #1;
        chk("pre_rst_valid", {31'h0, o_VALID}, 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, o_VALID}, 32'h0);
        chk("mid_rst_addr", o_lsu_addr, 32'h0);
        chk("mid_rst_strb", {28'h0, o_st_strb}, 32'h0);
        req_q.delete();
        resp_q.delete();
        i_mem_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h0BADF00D, 2,
               32'h0, 4'b1111, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 3, 4);

        repeat (2) @(negedge i_clk);
        chk("queues_drained", req_q.size() + resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
